addr_stack_feeder: RTL and testbench

Request sequencer that sits directly upstream of the 3-entry address stack. It accepts single- or dual-address request words over a valid/ready handshake and drives the stack's 2-bit `ctl` code and data word once per clock. It keeps a mirror of stack occupancy so the stack never overflows, and it drains the stack when idle or on flush. It also produces `addr_valid`, which tells the downstream consumer which cycles carry a real address on the stack's output.

---
 rtl/addr_stack_feeder.sv | 109 ++++++++++
 tb/tb_addr_stack_feeder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/addr_stack_feeder.sv
// addr_stack_feeder: sequences single/dual address requests into a 3-entry
// address stack, mirroring its occupancy so it never overflows, draining it
// when idle or on flush, and flagging which cycles carry a real address.
module addr_stack_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int STACK_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_kind,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [1:0]            stk_ctl,
  output logic [DATA_WIDTH-1:0] stk_data,
  input  logic                  stk_wait,
  output logic                  addr_valid,
  output logic [1:0]            occupancy,
  output logic                  flushing,
  output logic                  err_overflow
);

  localparam logic [1:0] OCC_FULL = 2'(STACK_SIZE);

  localparam logic [1:0] CTL_POP  = 2'b00;
  localparam logic [1:0] CTL_PASS = 2'b01;
  localparam logic [1:0] CTL_PUSH = 2'b11;

  logic [1:0]            ctl_reg, ctl_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [1:0]            occ_reg, occ_next;
  logic                  flushing_reg, flushing_next;
  logic                  emit_next;
  logic                  emit_d1_reg;
  logic                  addr_valid_reg;
  logic                  err_reg, err_next;
  logic                  accept;

  // Handshake: a flush pulse blocks the request in its own cycle as well as
  // for the whole drain; a dual request waits while the stack is full.
  always_comb begin
    req_ready = !rst && !flushing_reg && !flush &&
                !(req_kind && (occ_reg == OCC_FULL));
    accept    = req_valid && req_ready;
  end

  // Per-cycle stack command, occupancy update, flush tracking and error flag.
  always_comb begin
    ctl_next      = CTL_POP;
    data_next     = data_reg;
    occ_next      = occ_reg;
    emit_next     = 1'b0;
    flushing_next = flushing_reg;
    err_next      = err_reg | stk_wait;

    if (accept) begin
      emit_next = 1'b1;
      data_next = req_data;
      if (req_kind) begin
        ctl_next = CTL_PUSH;
        occ_next = occ_reg + 2'd1;
      end else begin
        ctl_next = CTL_PASS;
      end
    end else if (occ_reg != 2'd0) begin
      // Pop one stacked address; data word keeps its last value.
      emit_next = 1'b1;
      occ_next  = occ_reg - 2'd1;
    end

    // Drain ends once the stack is seen empty; a new flush pulse while
    // draining changes nothing.
    if (flushing_reg) begin
      flushing_next = (occ_reg != 2'd0);
    end else begin
      flushing_next = flush;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_reg        <= CTL_POP;
      data_reg       <= '0;
      occ_reg        <= 2'd0;
      flushing_reg   <= 1'b0;
      emit_d1_reg    <= 1'b0;
      addr_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      ctl_reg        <= ctl_next;
      data_reg       <= data_next;
      occ_reg        <= occ_next;
      flushing_reg   <= flushing_next;
      emit_d1_reg    <= emit_next;
      addr_valid_reg <= emit_d1_reg;
      err_reg        <= err_next;
    end
  end

  assign stk_ctl      = ctl_reg;
  assign stk_data     = data_reg;
  assign occupancy    = occ_reg;
  assign flushing     = flushing_reg;
  assign addr_valid   = addr_valid_reg;
  assign err_overflow = err_reg;

endmodule

// File: tb/tb_addr_stack_feeder.sv
// Testbench for addr_stack_feeder: directed scenarios followed by random
// traffic, each cycle compared against a behavioural stack-occupancy model.
module tb_addr_stack_feeder;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_kind = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready;
  logic          flush = 1'b0;
  logic [1:0]    stk_ctl;
  logic [DW-1:0] stk_data;
  logic          stk_wait = 1'b0;
  logic          addr_valid;
  logic [1:0]    occupancy;
  logic          flushing;
  logic          err_overflow;

  addr_stack_feeder #(.DATA_WIDTH(DW), .STACK_SIZE(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_kind(req_kind), .req_data(req_data),
    .req_ready(req_ready), .flush(flush),
    .stk_ctl(stk_ctl), .stk_data(stk_data), .stk_wait(stk_wait),
    .addr_valid(addr_valid), .occupancy(occupancy),
    .flushing(flushing), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference model: the stack as a count of stored upper halves, a drain
  // flag, and a record of whether the previous command produced an address.
  int      m_depth;
  bit      m_draining;
  int      m_ctl;
  int      m_data;
  bit      m_prev_emit;
  bit      m_addr_valid;
  bit      m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s step=%0d got=%h exp=%h", tag, n_step, got, exp);
    end
  endtask

  task automatic model_reset();
    m_depth = 0; m_draining = 0; m_ctl = 0; m_data = 0;
    m_prev_emit = 0; m_addr_valid = 0; m_err = 0;
  endtask

  // One clock cycle of stimulus; checks handshake before the edge and all
  // registered outputs after it.
  task automatic step(input bit v, input bit k, input logic [DW-1:0] d,
                      input bit f, input bit w);
    bit exp_ready, acc, emit;
    @(negedge clk);
    req_valid = v; req_kind = k; req_data = d; flush = f; stk_wait = w;
    #1;
    exp_ready = !m_draining && !f && !(k && m_depth == 3);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = v && exp_ready;
    if (acc) begin
      m_ctl  = k ? 3 : 1;
      m_data = int'(d);
      m_depth = m_depth + (k ? 1 : 0);
      emit = 1;
    end else begin
      m_ctl = 0;
      emit = (m_depth > 0);
      if (m_depth > 0) m_depth = m_depth - 1;
    end
    if (m_draining) m_draining = (m_depth + (emit && !acc ? 1 : 0)) != 0;
    else            m_draining = f;
    m_addr_valid = m_prev_emit;
    m_prev_emit  = emit;
    m_err = m_err | w;
    @(posedge clk);
    #1;
    n_step++;
    chk("stk_ctl", 32'(stk_ctl), 32'(m_ctl));
    chk("stk_data", 32'(stk_data), 32'(m_data));
    chk("occupancy", 32'(occupancy), 32'(m_depth));
    chk("flushing", 32'(flushing), 32'(m_draining));
    chk("addr_valid", 32'(addr_valid), 32'(m_addr_valid));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
    $display("step %0d v=%0d k=%0d d=%h f=%0d acc=%0d ctl=%0d occ=%0d av=%0d",
             n_step, v, k, d, f, acc, stk_ctl, occupancy, addr_valid);
  endtask

  // Assert reset between edges and check that every output clears at once.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    req_valid = 0; flush = 0; stk_wait = 0;
    #1;
    model_reset();
    chk("rst_ctl", 32'(stk_ctl), 32'd0);
    chk("rst_data", 32'(stk_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_flushing", 32'(flushing), 32'd0);
    chk("rst_addr_valid", 32'(addr_valid), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset applied");
  endtask

  logic [DW-1:0] singles [4];

  initial begin
    singles[0] = 16'hA012; singles[1] = 16'hB034;
    singles[2] = 16'hC056; singles[3] = 16'hD078;
    model_reset();
    apply_reset();

    // Four back-to-back singles, then idle to see the addr_valid tail.
    for (int i = 0; i < 4; i++) step(1, 0, singles[i], 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 0);

    // Three duals, then a fourth held valid through the stall.
    for (int i = 0; i < 3; i++) step(1, 1, 16'h1100 + 16'(i), 0, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 16'h2200, 0, 0);

    // Drain from full with no requests.
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0, 0);

    // Occupancy 2, flush together with a held request.
    step(1, 1, 16'h3301, 0, 0);
    step(1, 1, 16'h3302, 0, 0);
    step(1, 0, 16'h4400, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h4400, 0, 0);

    // Flush at occupancy 0.
    step(0, 0, 16'h0, 1, 0);
    step(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 0);

    // One-cycle overflow indication is sticky.
    step(0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h5500 + 16'(i), 0, 0);

    // Reset while occupancy 2 and addr_valid high.
    step(1, 1, 16'h6601, 0, 0);
    step(1, 1, 16'h6602, 0, 0);
    step(1, 1, 16'h6603, 0, 0);
    step(0, 0, 16'h0, 0, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 0);
    step(1, 1, 16'h7701, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 300) apply_reset();
      step(($urandom % 4) != 0, $urandom % 2, 16'($urandom),
           ($urandom % 25) == 0, (i == 150));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
